// File: rtl/kiwi_boot_pkg.sv
// Shared boot-sequencer types: FSM states, error codes, CPU reset-vector bit indices.
// Pure declarations; no latency or backpressure of its own.
package kiwi_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_CHK,
    ST_BOOT,
    ST_RUN,
    ST_ERROR
  } boot_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  // Bit positions within the CPU's rst[2:1] vector, shared with the CPU core.
  localparam int RST_LOAD = 1;
  localparam int RST_RUN  = 2;

  function automatic logic [2:1] rst_vec(input boot_state_t s);
    logic [2:1] v;
    v = '0;
    case (s)
      ST_LOAD, ST_CHK: v[RST_LOAD] = 1'b1;
      ST_BOOT, ST_RUN: v[RST_RUN]  = 1'b1;
      default:         v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/boot_csum16.sv
// 16-bit modulo running sum with clear/enable; o_zero flags (sum + i_data) == 0.
// Sum updates one cycle after i_en; o_zero is combinational; no backpressure.
module boot_csum16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [15:0] i_data,
  output logic        o_zero
);

  logic [15:0] r_sum;
  logic [15:0] w_sum_nxt;

  assign w_sum_nxt = r_sum + i_data;
  assign o_zero    = (w_sum_nxt == 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= w_sum_nxt;
    end
  end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: loads a length-prefixed image into code BRAM, verifies checksum, releases CPU.
// Registered outputs, BRAM write one cycle after accept; s_ready only in HDR/LOAD/CHK, one word/clock.
module cpu_boot_ctrl
  import kiwi_boot_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [15:0]       s_data,
  output logic              s_ready,
  output logic              code_we,
  output logic [ADDR_W-1:0] code_addr,
  output logic [15:0]       code_data,
  output logic [2:1]        cpu_rst,
  output logic              boot_done,
  output logic              busy,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam logic [ADDR_W-1:0] MAX_W = ADDR_W'(MAX_WORDS);

  boot_state_t       r_state;
  boot_state_t       w_next;
  logic [1:0]        w_err_nxt;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_words_loaded;
  logic [1:0]        r_err;
  logic              r_code_we;
  logic [ADDR_W-1:0] r_code_addr;
  logic [15:0]       r_code_data;
  logic [2:1]        r_cpu_rst;
  logic              r_boot_done;
  logic              r_busy;

  logic w_acc;
  logic w_start_ok;
  logic w_hdr_ok;
  logic w_last;
  logic w_wr;
  logic w_csum_zero;

  assign s_ready    = (r_state == ST_HDR) || (r_state == ST_LOAD) || (r_state == ST_CHK);
  // abort masks every side effect of a word presented in the same cycle
  assign w_acc      = s_valid & s_ready & ~abort;
  assign w_start_ok = start & ~abort &
                      ((r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_ERROR));
  assign w_hdr_ok   = (s_data != 16'h0000) && (s_data <= 16'(MAX_WORDS));
  assign w_last     = (r_words_loaded == r_len - ADDR_W'(1));
  assign w_wr       = w_acc && (r_state == ST_LOAD);

  boot_csum16 u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start_ok),
    .i_en   (w_wr),
    .i_data (s_data),
    .o_zero (w_csum_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_nxt = r_err;
    if (abort) begin
      w_next = ST_IDLE;
    end else if (w_start_ok) begin
      w_next    = ST_HDR;
      w_err_nxt = ERR_NONE;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (w_acc) begin
            if (w_hdr_ok) begin
              w_next = ST_LOAD;
            end else begin
              w_next    = ST_ERROR;
              w_err_nxt = ERR_LEN;
            end
          end
        end
        ST_LOAD: begin
          if (w_acc && w_last) w_next = ST_CHK;
        end
        ST_CHK: begin
          if (w_acc) begin
            if (w_csum_zero) begin
              w_next = ST_BOOT;
            end else begin
              w_next    = ST_ERROR;
              w_err_nxt = ERR_CSUM;
            end
          end
        end
        ST_BOOT: w_next = ST_RUN;
        default: w_next = r_state;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err          <= ERR_NONE;
      r_cpu_rst      <= '0;
      r_boot_done    <= 1'b0;
      r_busy         <= 1'b0;
      r_code_we      <= 1'b0;
      r_code_addr    <= '0;
      r_code_data    <= '0;
      r_len          <= '0;
      r_words_loaded <= '0;
    end else begin
      r_err       <= w_err_nxt;
      r_cpu_rst   <= rst_vec(w_next);
      r_boot_done <= (w_next == ST_BOOT);
      r_busy      <= (w_next == ST_HDR) || (w_next == ST_LOAD) ||
                     (w_next == ST_CHK) || (w_next == ST_BOOT);
      r_code_we   <= w_wr;
      if (w_wr) begin
        r_code_addr <= r_words_loaded;
        r_code_data <= s_data;
      end
      if (w_start_ok) begin
        r_len          <= '0;
        r_words_loaded <= '0;
      end else begin
        if ((r_state == ST_HDR) && w_acc && w_hdr_ok) r_len <= s_data[ADDR_W-1:0];
        if (w_wr && (r_words_loaded != MAX_W)) r_words_loaded <= r_words_loaded + ADDR_W'(1);
      end
    end
  end

  assign err          = r_err;
  assign cpu_rst      = r_cpu_rst;
  assign boot_done    = r_boot_done;
  assign busy         = r_busy;
  assign code_we      = r_code_we;
  assign code_addr    = r_code_addr;
  assign code_data    = r_code_data;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: good/bad images, length bounds, stalls, abort, async reset.
module tb_cpu_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_ready;
  logic        code_we;
  logic [10:0] code_addr;
  logic [15:0] code_data;
  logic [2:1]  cpu_rst;
  logic        boot_done;
  logic        busy;
  logic [1:0]  err;
  logic [10:0] words_loaded;

  int n_cmp = 0;
  int n_bad = 0;
  int n_writes = 0;
  int n_boot = 0;

  logic [15:0] img [3] = '{16'h1234, 16'h0001, 16'h8000};

  always #5 clk = ~clk;

  cpu_boot_ctrl #(.ADDR_W(11), .MAX_WORDS(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .code_we      (code_we),
    .code_addr    (code_addr),
    .code_data    (code_data),
    .cpu_rst      (cpu_rst),
    .boot_done    (boot_done),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always @(negedge clk) begin
    if (code_we) n_writes++;
    if (boot_done) n_boot++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && t < 20) begin
      tick();
      t++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
    end else begin
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_rst, boot_done, code_we, s_ready, busy, err} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 00000000", {cpu_rst, boot_done, code_we, s_ready, busy, err});
    end
    n_cmp++;
    if ({code_addr, code_data, words_loaded} !== 38'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h required 0", {code_addr, code_data, words_loaded});
    end
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic run_good_image(input string tag);
    int b0, w0;
    b0 = n_boot;
    w0 = n_writes;
    pulse_start();
    n_cmp++;
    if ({busy, s_ready, cpu_rst, err, words_loaded} !== {1'b1, 1'b1, 2'b00, 2'b00, 11'd0}) begin
      n_bad++;
      $display("FAIL %s_hdr: busy/rdy/rst/err/wl=%b/%b/%b/%0d/%0d required 1/1/00/0/0",
               tag, busy, s_ready, cpu_rst, err, words_loaded);
    end
    send_word(16'd3);
    n_cmp++;
    if (cpu_rst !== 2'b01) begin
      n_bad++;
      $display("FAIL %s_load_rst: cpu_rst=%b required 01", tag, cpu_rst);
    end
    for (int i = 0; i < 3; i++) begin
      send_word(img[i]);
      n_cmp++;
      if ({code_we, code_addr, code_data} !== {1'b1, 11'(i), img[i]}) begin
        n_bad++;
        $display("FAIL %s_write%0d: we/addr/data=%b/%0d/%h required 1/%0d/%h",
                 tag, i, code_we, code_addr, code_data, i, img[i]);
      end
    end
    n_cmp++;
    if (words_loaded !== 11'd3) begin
      n_bad++;
      $display("FAIL %s_words_loaded: got %0d required 3", tag, words_loaded);
    end
    send_word(16'h6DCB);
    n_cmp++;
    if ({boot_done, cpu_rst, code_we} !== {1'b1, 2'b10, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_boot: done/rst/we=%b/%b/%b required 1/10/0", tag, boot_done, cpu_rst, code_we);
    end
    tick();
    n_cmp++;
    if ({boot_done, cpu_rst, busy, err, words_loaded} !== {1'b0, 2'b10, 1'b0, 2'b00, 11'd3}) begin
      n_bad++;
      $display("FAIL %s_run: done/rst/busy/err/wl=%b/%b/%b/%0d/%0d required 0/10/0/0/3",
               tag, boot_done, cpu_rst, busy, err, words_loaded);
    end
    tick();
    tick();
    n_cmp++;
    if ((n_boot - b0) !== 1 || (n_writes - w0) !== 3) begin
      n_bad++;
      $display("FAIL %s_pulses: boot_done pulses=%0d writes=%0d required 1 and 3",
               tag, n_boot - b0, n_writes - w0);
    end
  endtask

  task automatic test_restart_from_run();
    pulse_start();
    n_cmp++;
    if ({cpu_rst, busy, s_ready} !== {2'b00, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL restart_hdr: rst/busy/rdy=%b/%b/%b required 00/1/1", cpu_rst, busy, s_ready);
    end
    pulse_abort();
    n_cmp++;
    if ({s_ready, busy, cpu_rst} !== 4'b0000) begin
      n_bad++;
      $display("FAIL restart_abort: rdy/busy/rst=%b/%b/%b required 0/0/00", s_ready, busy, cpu_rst);
    end
  endtask

  task automatic test_bad_csum();
    int b0;
    pulse_start();
    send_word(16'd3);
    for (int i = 0; i < 3; i++) send_word(img[i]);
    b0 = n_boot;
    send_word(16'h0000);
    n_cmp++;
    if ({err, cpu_rst, s_ready, busy, boot_done} !== {2'd2, 2'b00, 3'b000}) begin
      n_bad++;
      $display("FAIL csum_err: err/rst/rdy/busy/done=%0d/%b/%b/%b/%b required 2/00/0/0/0",
               err, cpu_rst, s_ready, busy, boot_done);
    end
    repeat (3) tick();
    n_cmp++;
    if ((n_boot !== b0) || (err !== 2'd2) || (cpu_rst !== 2'b00)) begin
      n_bad++;
      $display("FAIL csum_sticky: extra boots=%0d err=%0d rst=%b required 0/2/00", n_boot - b0, err, cpu_rst);
    end
  endtask

  task automatic test_bad_len();
    int w0;
    w0 = n_writes;
    pulse_start();
    n_cmp++;
    if (err !== 2'd0) begin
      n_bad++;
      $display("FAIL len_err_clear: err=%0d required 0", err);
    end
    send_word(16'd0);
    n_cmp++;
    if ({err, cpu_rst, s_ready} !== {2'd1, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL len_zero: err/rst/rdy=%0d/%b/%b required 1/00/0", err, cpu_rst, s_ready);
    end
    pulse_start();
    send_word(16'd1025);
    n_cmp++;
    if ({err, cpu_rst, s_ready} !== {2'd1, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL len_1025: err/rst/rdy=%0d/%b/%b required 1/00/0", err, cpu_rst, s_ready);
    end
    tick();
    n_cmp++;
    if (n_writes !== w0) begin
      n_bad++;
      $display("FAIL len_no_write: writes=%0d required 0", n_writes - w0);
    end
    pulse_start();
    send_word(16'd1024);
    n_cmp++;
    if ({err, cpu_rst, s_ready} !== {2'd0, 2'b01, 1'b1}) begin
      n_bad++;
      $display("FAIL len_1024: err/rst/rdy=%0d/%b/%b required 0/01/1", err, cpu_rst, s_ready);
    end
    pulse_abort();
  endtask

  task automatic test_stall();
    int w0;
    int stalls;
    pulse_start();
    send_word(16'd3);
    w0 = n_writes;
    for (int i = 0; i < 3; i++) begin
      stalls = $urandom_range(0, 3);
      for (int k = 0; k < stalls; k++) begin
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        tick();
        n_cmp++;
        if (code_we !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_we%0d_%0d: code_we=%b required 0", i, k, code_we);
        end
      end
      s_valid = 1'b1;
      s_data  = img[i];
      tick();
      n_cmp++;
      if ({code_we, code_addr, code_data} !== {1'b1, 11'(i), img[i]}) begin
        n_bad++;
        $display("FAIL stall_write%0d: we/addr/data=%b/%0d/%h required 1/%0d/%h",
                 i, code_we, code_addr, code_data, i, img[i]);
      end
    end
    s_valid = 1'b0;
    tick();
    n_cmp++;
    if ((code_we !== 1'b0) || (s_ready !== 1'b1)) begin
      n_bad++;
      $display("FAIL stall_chk_idle: we/rdy=%b/%b required 0/1", code_we, s_ready);
    end
    send_word(16'h6DCB);
    n_cmp++;
    if ({boot_done, cpu_rst} !== 3'b110 || (n_writes - w0) !== 3) begin
      n_bad++;
      $display("FAIL stall_boot: done/rst=%b/%b writes=%0d required 1/10 and 3",
               boot_done, cpu_rst, n_writes - w0);
    end
    tick();
  endtask

  task automatic test_abort();
    int w0;
    w0 = n_writes;
    pulse_start();
    send_word(16'd3);
    send_word(img[0]);
    send_word(img[1]);
    abort   = 1'b1;
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = img[2];
    tick();
    abort   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    n_cmp++;
    if ({code_we, cpu_rst, s_ready, busy, err} !== 7'b0) begin
      n_bad++;
      $display("FAIL abort_idle: we/rst/rdy/busy/err=%b/%b/%b/%b/%0d required 0/00/0/0/0",
               code_we, cpu_rst, s_ready, busy, err);
    end
    n_cmp++;
    if (words_loaded !== 11'd2) begin
      n_bad++;
      $display("FAIL abort_words: words_loaded=%0d required 2", words_loaded);
    end
    tick();
    n_cmp++;
    if ((n_writes - w0) !== 2 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_writes: writes=%0d rdy=%b required 2/0", n_writes - w0, s_ready);
    end
    run_good_image("after_abort");
  endtask

  task automatic test_async_reset();
    pulse_start();
    send_word(16'd3);
    send_word(img[0]);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_rst, boot_done, code_we, s_ready, busy, err, code_addr, code_data, words_loaded} !== 46'h0) begin
      n_bad++;
      $display("FAIL arst_load: outputs=%h required 0",
               {cpu_rst, boot_done, code_we, s_ready, busy, err, code_addr, code_data, words_loaded});
    end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({s_ready, busy, cpu_rst} !== 4'b0) begin
      n_bad++;
      $display("FAIL arst_load_idle: rdy/busy/rst=%b/%b/%b required 0/0/00", s_ready, busy, cpu_rst);
    end
    run_good_image("pre_arst");
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_rst, boot_done, code_we, s_ready, busy, err, code_addr, code_data, words_loaded} !== 46'h0) begin
      n_bad++;
      $display("FAIL arst_run: outputs=%h required 0",
               {cpu_rst, boot_done, code_we, s_ready, busy, err, code_addr, code_data, words_loaded});
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    run_good_image("good");
    test_restart_from_run();
    test_bad_csum();
    test_bad_len();
    test_stall();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
